// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } mem_size_t;

    localparam int unsigned WORD_BYTES = 4;

    typedef struct packed {
        logic [WORD_BYTES-1:0] be;
        logic [31:0]           wdata;
        logic                  err;
    } wr_lane_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32I accesses: store enables/data, alignment
// check and load extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]            size_i,
    input  logic [1:0]            addr_lo_i,
    input  logic [31:0]           wdata_i,
    input  logic [31:0]           raw_i,
    output logic [WORD_BYTES-1:0] be_o,
    output logic [31:0]           wdata_o,
    output logic                  err_o,
    output logic [31:0]           rdata_o
);

    function automatic wr_lane_t align_store(input logic [2:0] size, input logic [1:0] a,
                                             input logic [31:0] wd);
        wr_lane_t r;
        r.be    = '0;
        r.wdata = '0;
        r.err   = 1'b0;
        case (size)
            SZ_B, SZ_BU: begin
                r.be    = 4'b0001 << a;
                r.wdata = {4{wd[7:0]}};
            end
            SZ_H, SZ_HU: begin
                r.err   = a[0];
                r.be    = a[1] ? 4'b1100 : 4'b0011;
                r.wdata = {2{wd[15:0]}};
            end
            SZ_W: begin
                r.err   = |a;
                r.be    = 4'b1111;
                r.wdata = wd;
            end
            default: r.err = 1'b1;
        endcase
        // An erroring access must never touch the RAM.
        if (r.err) begin
            r.be = '0;
        end
        return r;
    endfunction

    function automatic logic [31:0] extend_load(input logic [2:0] size, input logic [1:0] a,
                                                input logic [31:0] raw);
        logic [31:0] sh;
        sh = raw >> {a, 3'b000};
        case (size)
            SZ_B:    return {{24{sh[7]}}, sh[7:0]};
            SZ_BU:   return {24'b0, sh[7:0]};
            SZ_H:    return {{16{sh[15]}}, sh[15:0]};
            SZ_HU:   return {16'b0, sh[15:0]};
            default: return raw;
        endcase
    endfunction

    wr_lane_t st;

    always_comb begin
        st      = align_store(size_i, addr_lo_i, wdata_i);
        be_o    = st.be;
        wdata_o = st.wdata;
        err_o   = st.err;
        rdata_o = extend_load(size_i, addr_lo_i, raw_i);
    end

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: valid/ready request, fixed-latency one-cycle response,
// internal byte-addressed RAM. Optional counters under DMEM_STATS_EN.
module data_mem_resp
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned MEM_ADDR_BITS = 12,
    parameter int unsigned WAIT_CYCLES   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_size,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  busy
`ifdef DMEM_STATS_EN
   ,output logic [15:0]           stat_reads,
    output logic [15:0]           stat_writes,
    output logic [15:0]           stat_errs
`endif
);

    localparam int unsigned Words     = 1 << (MEM_ADDR_BITS - 2);
    localparam logic [3:0]  WaitLoad  = 4'(WAIT_CYCLES - 1);

    dmem_state_t              state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic                     write_q, write_d;
    logic [2:0]               size_q, size_d;
    logic [MEM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]    resp_rdata_q, resp_rdata_d;
    logic                     resp_err_q, resp_err_d;
    logic                     resp_write_q, resp_write_d;

    logic [DATA_WIDTH-1:0]    mem_q [Words];

    logic                     accept, commit;
    logic                     cur_write;
    logic [2:0]               cur_size;
    logic [MEM_ADDR_BITS-1:0] cur_addr;
    logic [DATA_WIDTH-1:0]    cur_wdata;
    logic [WORD_BYTES-1:0]    lane_be;
    logic [31:0]              lane_wdata, lane_rdata;
    logic                     lane_err;
    logic                     unused_addr;

    assign unused_addr = ^req_addr[ADDR_WIDTH-1:MEM_ADDR_BITS];

    // With zero wait states the access commits on the accept edge, so the
    // live request is used instead of the latched copy.
    always_comb begin
        if (state_q == IDLE) begin
            cur_write = req_write;
            cur_size  = req_size;
            cur_addr  = req_addr[MEM_ADDR_BITS-1:0];
            cur_wdata = req_wdata;
        end else begin
            cur_write = write_q;
            cur_size  = size_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end
    end

    assign accept = req_ready && req_valid;
    assign commit = !rst && ((accept && (WAIT_CYCLES == 0)) ||
                             (state_q == WAIT && cnt_q == 4'd0));

    dmem_lane_align u_lane_align (
        .size_i    (cur_size),
        .addr_lo_i (cur_addr[1:0]),
        .wdata_i   (cur_wdata),
        .raw_i     (mem_q[cur_addr[MEM_ADDR_BITS-1:2]]),
        .be_o      (lane_be),
        .wdata_o   (lane_wdata),
        .err_o     (lane_err),
        .rdata_o   (lane_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            write_q      <= 1'b0;
            size_q       <= 3'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            resp_write_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            resp_write_q <= resp_write_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WaitLoad;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        write_d      = write_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        resp_write_d = resp_write_q;
        if (accept) begin
            write_d = req_write;
            size_d  = req_size;
            addr_d  = req_addr[MEM_ADDR_BITS-1:0];
            wdata_d = req_wdata;
        end
        if (commit) begin
            resp_err_d   = lane_err;
            resp_write_d = cur_write;
            resp_rdata_d = (lane_err || cur_write) ? '0 : lane_rdata;
        end
    end

    always_comb begin
        req_ready  = (state_q == IDLE) && !rst;
        resp_valid = (state_q == RESP);
        busy       = (state_q != IDLE);
        resp_rdata = resp_rdata_q;
        resp_err   = resp_err_q;
    end

    // RAM is not reset; lane_be is already zero for erroring accesses.
    always_ff @(posedge clk) begin
        if (commit && cur_write) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (lane_be[i]) begin
                    mem_q[cur_addr[MEM_ADDR_BITS-1:2]][8*i +: 8] <= lane_wdata[8*i +: 8];
                end
            end
        end
    end

`ifdef DMEM_STATS_EN
    logic [15:0] stat_reads_q, stat_reads_d;
    logic [15:0] stat_writes_q, stat_writes_d;
    logic [15:0] stat_errs_q, stat_errs_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_reads_q  <= 16'd0;
            stat_writes_q <= 16'd0;
            stat_errs_q   <= 16'd0;
        end else begin
            stat_reads_q  <= stat_reads_d;
            stat_writes_q <= stat_writes_d;
            stat_errs_q   <= stat_errs_d;
        end
    end

    always_comb begin
        stat_reads_d  = stat_reads_q;
        stat_writes_d = stat_writes_q;
        stat_errs_d   = stat_errs_q;
        if (resp_valid) begin
            if (resp_err_q) begin
                if (stat_errs_q != 16'hFFFF) stat_errs_d = stat_errs_q + 16'd1;
            end else if (resp_write_q) begin
                if (stat_writes_q != 16'hFFFF) stat_writes_d = stat_writes_q + 16'd1;
            end else begin
                if (stat_reads_q != 16'hFFFF) stat_reads_d = stat_reads_q + 16'd1;
            end
        end
    end

    assign stat_reads  = stat_reads_q;
    assign stat_writes = stat_writes_q;
    assign stat_errs   = stat_errs_q;
`endif

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench: one instance with two wait states, one with none,
// both checked against a byte-array reference model.
module tb_data_mem_resp;

    logic        clk;
    logic        rst;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_write  [2];
    logic [2:0]  req_size   [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];
    logic        busy       [2];
`ifdef DMEM_STATS_EN
    logic [15:0] st_r [2];
    logic [15:0] st_w [2];
    logic [15:0] st_e [2];
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0] mem_m [2][4096];

    data_mem_resp #(.WAIT_CYCLES(2)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_size(req_size[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
        .busy(busy[0])
`ifdef DMEM_STATS_EN
       ,.stat_reads(st_r[0]), .stat_writes(st_w[0]), .stat_errs(st_e[0])
`endif
    );

    data_mem_resp #(.WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_size(req_size[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
        .busy(busy[1])
`ifdef DMEM_STATS_EN
       ,.stat_reads(st_r[1]), .stat_writes(st_w[1]), .stat_errs(st_e[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: byte array, size -> byte count, natural alignment rule.
    function automatic void model(input int d, input bit wr, input bit [2:0] sz,
                                  input bit [31:0] a, input bit [31:0] wd,
                                  output logic [31:0] exp, output bit err);
        int n;
        int base;
        bit [31:0] v;
        n    = (sz[1:0] == 2'd0) ? 1 : (sz[1:0] == 2'd1) ? 2 : 4;
        err  = !(sz inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || ((a % n) != 0);
        base = int'(a % 4096);
        exp  = 32'd0;
        if (err) return;
        if (wr) begin
            for (int i = 0; i < n; i++) mem_m[d][base + i] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v = v | (32'(mem_m[d][base + i]) << (8 * i));
            if (!sz[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
            exp = v;
        end
    endfunction

    task automatic txn(input int d, input bit wr, input bit [2:0] sz, input bit [31:0] a,
                       input bit [31:0] wd);
        logic [31:0] exp;
        bit          err;
        int          k;
        int          lat;
        k = 0;
        @(negedge clk);
        while (req_ready[d] !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("ready", 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_size[d]  = sz;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        model(d, wr, sz, a, wd, exp, err);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("busy", 32'(busy[d]), 32'd1);
            if (resp_valid[d] === 1'b1) begin
                lat = i;
                break;
            end
        end
        chk("latency", lat, (d == 0) ? 32'd2 : 32'd0);
        chk("rdata", resp_rdata[d], exp);
        chk("err", 32'(resp_err[d]), 32'(err));
    endtask

    initial begin
        bit [2:0]  szs [8];
        bit [31:0] a;
        int        acc;
        int        bcnt;
        int        rcnt;
        szs = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_write[d] = 1'b0;
            req_size[d]  = 3'd0;
            req_addr[d]  = 32'd0;
            req_wdata[d] = 32'd0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_in_reset", 32'(req_ready[0]), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready[0]), 32'd1);
        chk("rst_valid", 32'(resp_valid[0]), 32'd0);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_rdata", resp_rdata[0], 32'd0);
        chk("rst_err", 32'(resp_err[0]), 32'd0);

        // Word store/load, byte store with sign/zero extension.
        txn(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        txn(0, 1'b0, 3'b010, 32'h10, 32'h0);
        chk("lw_10", resp_rdata[0], 32'hDEADBEEF);
        txn(0, 1'b1, 3'b000, 32'h13, 32'h00000080);
        txn(0, 1'b0, 3'b000, 32'h13, 32'h0);
        chk("lb_13", resp_rdata[0], 32'hFFFFFF80);
        txn(0, 1'b0, 3'b100, 32'h13, 32'h0);
        chk("lbu_13", resp_rdata[0], 32'h00000080);
        txn(0, 1'b0, 3'b010, 32'h10, 32'h0);
        chk("lw_10b", resp_rdata[0], 32'h80ADBEEF);

        // Misaligned accesses.
        txn(0, 1'b1, 3'b010, 32'h20, 32'h11223344);
        txn(0, 1'b0, 3'b001, 32'h11, 32'h0);
        chk("lh_mis_err", 32'(resp_err[0]), 32'd1);
        txn(0, 1'b1, 3'b010, 32'h22, 32'hFFFFFFFF);
        chk("sw_mis_err", 32'(resp_err[0]), 32'd1);
        txn(0, 1'b0, 3'b010, 32'h20, 32'h0);
        chk("lw_20", resp_rdata[0], 32'h11223344);

        // Reset while a store waits: it must never land.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_size[0]  = 3'b010;
        req_addr[0]  = 32'h20;
        req_wdata[0] = 32'h99999999;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("midwait_busy", 32'(busy[0]), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_busy", 32'(busy[0]), 32'd0);
        chk("async_ready", 32'(req_ready[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rcnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid[0] === 1'b1) rcnt++;
            if (i == 0) chk("ready_after_rst", 32'(req_ready[0]), 32'd1);
        end
        chk("no_resp_after_rst", rcnt, 32'd0);
        txn(0, 1'b0, 3'b010, 32'h20, 32'h0);
        chk("lw_20_kept", resp_rdata[0], 32'h11223344);

        // Request held continuously: one accept every WAIT_CYCLES+2 cycles.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_size[0]  = 3'b010;
        req_addr[0]  = 32'h10;
        acc = 0;
        bcnt = 0;
        rcnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (req_ready[0] === 1'b1) acc++;
            if (busy[0] === 1'b1) bcnt++;
            if (resp_valid[0] === 1'b1) rcnt++;
            @(negedge clk);
        end
        req_valid[0] = 1'b0;
        chk("held_accepts", acc, 32'd3);
        chk("held_busy", bcnt, 32'd9);
        chk("held_resps", rcnt, 32'd3);

        // Zero wait states and address wrap.
        txn(1, 1'b1, 3'b010, 32'h010, 32'hCAFEF00D);
        txn(1, 1'b0, 3'b010, 32'h1010, 32'h0);
        chk("wrap_lw", resp_rdata[1], 32'hCAFEF00D);
        txn(1, 1'b0, 3'b011, 32'h010, 32'h0);
        chk("illegal_size", 32'(resp_err[1]), 32'd1);

        // Random traffic in a pre-filled region, upper address bits random.
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 64; w++) txn(d, 1'b1, 3'b010, 32'(w * 4), $urandom);
            for (int t = 0; t < 150; t++) begin
                a = {$urandom_range(0, 32'hFFFFF), 4'h0, 8'($urandom)};
                if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
                txn(d, 1'($urandom_range(0, 1)), szs[$urandom_range(0, 7)], a, $urandom);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
